ascii_uart_tx: RTL and testbench



---
 rtl/ascii_uart_pkg.sv | 22 ++
 rtl/uart_baud_counter.sv | 28 ++
 rtl/ascii_uart_tx.sv | 119 +++++++++++
 tb/tb_ascii_uart_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ascii_uart_pkg.sv
// Shared types, constants and the hex-digit to lowercase-ASCII encoder for the UART transmit path.
package ascii_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [7:0] ASCII_DIGIT_BASE = 8'd48;
  localparam logic [7:0] ASCII_LOWER_BASE = 8'd97;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] digit);
    if (digit < 4'd10)
      return ASCII_DIGIT_BASE + {4'd0, digit};
    else
      return ASCII_LOWER_BASE + {4'd0, digit} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic bit_tick
);

  localparam int unsigned W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign bit_tick = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (en)
      count <= bit_tick ? '0 : count + W'(1);
  end

endmodule

// File: rtl/ascii_uart_tx.sv
// Hex digit to ASCII UART transmitter, 8N1 LSB first; define ASCII_UART_TX_PARITY_EN for 8E1.
module ascii_uart_tx
  import ascii_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       send_valid,
  output logic       send_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic [7:0] ascii_out
);

  tx_state_t  state;
  logic       accept;
  logic       bit_tick;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
`ifdef ASCII_UART_TX_PARITY_EN
  logic       par;
`endif

  assign accept = send_valid && send_ready;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .en      (busy),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      send_ready <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      ascii_out  <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
`ifdef ASCII_UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ascii_out  <= hex_to_ascii(digit_in);
            shreg      <= hex_to_ascii(digit_in);
`ifdef ASCII_UART_TX_PARITY_EN
            par        <= ^hex_to_ascii(digit_in);
`endif
            bit_idx    <= '0;
            tx         <= 1'b0;
            send_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          // tx is registered, so the next bit is taken from shreg[1] as the register shifts
          if (bit_tick) begin
            if (bit_idx == 3'd7) begin
`ifdef ASCII_UART_TX_PARITY_EN
              tx    <= par;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end
        end
`ifdef ASCII_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            send_ready <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          tx         <= 1'b1;
          send_ready <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Randomized self-checking bench for ascii_uart_tx against a frame-level reference model.
module tb_ascii_uart_tx;

  localparam int unsigned C = 4;
`ifdef ASCII_UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int unsigned FRAME_CYCLES = FRAME_BITS * C;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit_in;
  logic       send_valid;
  logic       send_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [7:0] ascii_out;

  int n_checks = 0;
  int n_fail   = 0;

  ascii_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit_in  (digit_in),
    .send_valid(send_valid),
    .send_ready(send_ready),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .ascii_out (ascii_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_ascii(input int d);
    if (d < 10) return 8'(48 + d);
    return 8'(97 + (d - 10));
  endfunction

  // Line levels in transmit order: start, 8 data LSB first, optional even parity, stop.
  function automatic logic [FRAME_BITS-1:0] ref_frame(input logic [7:0] ch);
    logic [FRAME_BITS-1:0] bits;
    int ones;
    bits = '0;
    ones = 0;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bits[k+1] = ((ch >> k) & 8'd1) != 8'd0;
      if (bits[k+1]) ones++;
    end
`ifdef ASCII_UART_TX_PARITY_EN
    bits[9] = (ones % 2) == 1;
`endif
    bits[FRAME_BITS-1] = 1'b1;
    return bits;
  endfunction

  task automatic check_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check("idle", {tx, send_ready, busy, tx_done}, 4'b1100);
      step();
    end
  endtask

  // Caller is positioned #1 after an edge; the next edge is the accept edge.
  task automatic send_frame(input logic [3:0] d, input bit hold, input int pulse_at);
    logic [7:0] exp_ch;
    logic [FRAME_BITS-1:0] bits;
    exp_ch = ref_ascii(int'(d));
    bits   = ref_frame(exp_ch);
    digit_in   = d;
    send_valid = 1'b1;
    step();
    if (!hold) begin
      send_valid = 1'b0;
      digit_in   = 4'($urandom);
    end
    check("ascii_out", ascii_out, exp_ch);
    for (int i = 0; i < int'(FRAME_CYCLES); i++) begin
      check("tx_bit", tx, bits[i / C]);
      check("in_flight", {busy, send_ready, tx_done}, 3'b100);
      if (!hold) begin
        if (i == pulse_at) begin
          send_valid = 1'b1;
          digit_in   = 4'h3;
        end else begin
          send_valid = 1'b0;
        end
      end
      step();
    end
    check("frame_end", {tx, busy, send_ready, tx_done}, 4'b1011);
    check("ascii_held", ascii_out, exp_ch);
  endtask

  initial begin
    logic [3:0] d;
    bit hold;
    int pulse;

    rst_n      = 1'b0;
    send_valid = 1'b0;
    digit_in   = 4'h0;
    #1;
    repeat (3) step();
    check("reset_out", {tx, send_ready, busy, tx_done}, 4'b1100);
    check("reset_ascii", ascii_out, 8'h00);
    rst_n = 1'b1;
    check_idle(50);

    // single frame '5', then tx_done must drop after one cycle
    send_frame(4'h5, 1'b0, -1);
    step();
    check("done_pulse", tx_done, 1'b0);
    check_idle(3);

    // 'a' held for two back-to-back frames
    send_frame(4'hA, 1'b1, -1);
    send_frame(4'hA, 1'b0, -1);
    step();
    check_idle(2);

    // mid-frame request with '3' is ignored
    send_frame(4'h7, 1'b0, 13);
    step();
    check("ignored_req", {tx, send_ready, busy, tx_done}, 4'b1100);
    check_idle(FRAME_CYCLES);

    // reset during data bit 3 of '5'
    digit_in   = 4'h5;
    send_valid = 1'b1;
    step();
    send_valid = 1'b0;
    repeat (17) step();
    check("pre_reset_tx", tx, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {tx, send_ready, busy, tx_done}, 4'b1100);
    check("async_ascii", ascii_out, 8'h00);
    repeat (2) step();
    rst_n = 1'b1;
    check_idle(FRAME_CYCLES);
    send_frame(4'hF, 1'b0, -1);
    step();
    check_idle(2);

    // randomized frames, random gaps, random back-to-back and ignored requests
    for (int n = 0; n < 12; n++) begin
      d     = 4'($urandom_range(0, 15));
      hold  = ($urandom_range(0, 2) == 0);
      pulse = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FRAME_CYCLES - 3)) : -1;
      send_frame(d, hold, pulse);
      if (!hold) begin
        step();
        check_idle(int'($urandom_range(0, 3)));
      end
    end
    send_valid = 1'b0;
    step();
    check_idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
